// File: rtl/htd_rr_arb_if.sv
// Requester-side bundle for htd_rr_arb: per-requester request/data/strobe in,
// shared grant, forwarded word and status pulses out.
interface htd_rr_arb_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned NUM_REQ    = 4
);
    logic [NUM_REQ-1:0]            iv_req;
    logic [NUM_REQ*DATA_WIDTH-1:0] iv_data;
    logic [NUM_REQ-1:0]            iv_data_wr;
    logic [NUM_REQ-1:0]            ov_gnt;
    logic [DATA_WIDTH-1:0]         ov_data;
    logic                          o_data_wr;
    logic                          o_timeout;
    logic                          o_err;
    logic                          o_trunc;

    modport slave (
        input  iv_req, iv_data, iv_data_wr,
        output ov_gnt, ov_data, o_data_wr, o_timeout, o_err, o_trunc
    );

    modport master (
        output iv_req, iv_data, iv_data_wr,
        input  ov_gnt, ov_data, o_data_wr, o_timeout, o_err, o_trunc
    );
endinterface

// File: rtl/htd_rr_arb.sv
// Round-robin frame arbiter feeding one htd framing stage, with a forced idle
// gap after every frame. Define HTD_ARB_MAXLEN_EN to cap frames at MAX_LEN words.
module htd_rr_arb #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned TIMEOUT    = 16,
    parameter int unsigned GAP_CYCLES = 2,
    parameter int unsigned MAX_LEN    = 64
) (
    input logic        i_clk,
    input logic        i_rst,
    htd_rr_arb_if.slave bus
);

    localparam int unsigned IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned GAP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT < 2 || GAP_CYCLES < 1 || MAX_LEN < 1) begin : g_bad_params
        $error("htd_rr_arb: parameter out of range");
    end

    typedef enum logic [1:0] {IDLE, GRANT, XFER, GAP} state_t;

    state_t            state;
    logic [IDX_W-1:0]  last;
    logic [IDX_W-1:0]  owner;
    logic [WAIT_W-1:0] wait_cnt;
    logic [GAP_W-1:0]  gap_cnt;

`ifdef HTD_ARB_MAXLEN_EN
    localparam int unsigned CNT_W = $clog2(MAX_LEN + 1);
    logic [CNT_W-1:0]  word_cnt;
`endif

    logic [IDX_W-1:0]      pick;
    logic                  pick_valid;
    logic                  gnt_wr;
    logic                  gnt_req;
    logic                  stray_wr;
    logic [DATA_WIDTH-1:0] gnt_data;

    function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base, input int unsigned off);
        return IDX_W'((32'(base) + off) % NUM_REQ);
    endfunction

    // Search starts just past the last winner, so the most recent winner is tried last.
    always_comb begin
        pick       = '0;
        pick_valid = 1'b0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            if (!pick_valid && bus.iv_req[wrap_idx(last, i)]) begin
                pick_valid = 1'b1;
                pick       = wrap_idx(last, i);
            end
        end
    end

    assign gnt_wr   = |(bus.iv_data_wr & bus.ov_gnt);
    assign gnt_req  = |(bus.iv_req & bus.ov_gnt);
    assign stray_wr = |(bus.iv_data_wr & ~bus.ov_gnt);
    assign gnt_data = bus.iv_data[32'(owner)*DATA_WIDTH +: DATA_WIDTH];

`ifndef HTD_ARB_MAXLEN_EN
    assign bus.o_trunc = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state         <= IDLE;
            last          <= IDX_W'(NUM_REQ - 1);
            owner         <= '0;
            wait_cnt      <= '0;
            gap_cnt       <= '0;
            bus.ov_gnt    <= '0;
            bus.ov_data   <= '0;
            bus.o_data_wr <= 1'b0;
            bus.o_timeout <= 1'b0;
            bus.o_err     <= 1'b0;
`ifdef HTD_ARB_MAXLEN_EN
            bus.o_trunc   <= 1'b0;
            word_cnt      <= '0;
`endif
        end else begin
            bus.o_err     <= stray_wr;
            bus.o_timeout <= 1'b0;
            bus.o_data_wr <= 1'b0;
`ifdef HTD_ARB_MAXLEN_EN
            bus.o_trunc   <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        bus.ov_gnt <= NUM_REQ'(1) << pick;
                        owner      <= pick;
                        last       <= pick;
                        wait_cnt   <= '0;
                        state      <= GRANT;
                    end
                end
                GRANT: begin
                    if (gnt_wr) begin
                        bus.ov_data   <= gnt_data;
                        bus.o_data_wr <= 1'b1;
                        state         <= XFER;
`ifdef HTD_ARB_MAXLEN_EN
                        word_cnt      <= CNT_W'(1);
`endif
                    end else if (!gnt_req) begin
                        bus.ov_gnt <= '0;
                        state      <= IDLE;
                    end else if (wait_cnt == WAIT_W'(TIMEOUT - 1)) begin
                        bus.ov_gnt    <= '0;
                        bus.o_timeout <= 1'b1;
                        state         <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                XFER: begin
                    if (gnt_wr) begin
`ifdef HTD_ARB_MAXLEN_EN
                        if (word_cnt == CNT_W'(MAX_LEN)) begin
                            bus.ov_gnt  <= '0;
                            bus.o_trunc <= 1'b1;
                            gap_cnt     <= '0;
                            state       <= GAP;
                        end else begin
                            bus.ov_data   <= gnt_data;
                            bus.o_data_wr <= 1'b1;
                            word_cnt      <= word_cnt + 1'b1;
                        end
`else
                        bus.ov_data   <= gnt_data;
                        bus.o_data_wr <= 1'b1;
`endif
                    end else begin
                        bus.ov_gnt <= '0;
                        gap_cnt    <= '0;
                        state      <= GAP;
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) begin
                        state <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
